// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel processing datapath: channel widths,
// luma coefficients (sum to 256) and the packed {R,G,B} pixel type.
package pixel_pkg;

  localparam int PIXEL_SIZE = 24;
  localparam int CHAN_W     = 8;
  localparam int SUM_W      = 16;

  localparam logic [SUM_W-1:0] COEF_R = 16'd77;
  localparam logic [SUM_W-1:0] COEF_G = 16'd150;
  localparam logic [SUM_W-1:0] COEF_B = 16'd29;

  // Field order puts R in the top byte and B in the bottom byte.
  typedef struct packed {
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] b;
  } rgb_t;

  // Weighted sum; worst case 255*256 = 65280 fits in 16 bits.
  function automatic logic [SUM_W-1:0] luma_sum(input rgb_t p);
    return COEF_R * SUM_W'(p.r) + COEF_G * SUM_W'(p.g) + COEF_B * SUM_W'(p.b);
  endfunction

endpackage

// File: rtl/rgb_to_luma.sv
// First two pipeline stages: capture the pixel, then form the weighted luma
// sum. The 8-bit luma is the truncated upper byte of the registered sum.
module rgb_to_luma
  import pixel_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [PIXEL_SIZE-1:0] data,
  output logic [CHAN_W-1:0]     y
);

  rgb_t             s1_q;
  logic [SUM_W-1:0] sum_q;
  logic [7:0]       unused_frac;

  // S1 captures the raw pixel, S2 registers its luma sum; both hold when en=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= '0;
      sum_q <= '0;
    end else if (en) begin
      s1_q  <= rgb_t'(data);
      sum_q <= luma_sum(s1_q);
    end
  end

  // Truncation rather than rounding: the fractional byte is discarded.
  assign y           = sum_q[SUM_W-1 -: CHAN_W];
  assign unused_frac = sum_q[7:0];

endmodule

// File: rtl/pixel_proc_top.sv
// Streaming pixel-to-luma processor, latency 3 enabled edges from capture
// to out (data sampled at edge n shows on out after edge n+2).
// Build option: define THRESHOLD_EN to binarise luma against THRESHOLD
// (Y >= THRESHOLD gives white); otherwise luma is replicated on {Y,Y,Y}.
module pixel_proc_top #(
  parameter int          PIXEL_SIZE = 24,
  parameter int unsigned THRESHOLD  = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [PIXEL_SIZE-1:0] data,
  output logic [PIXEL_SIZE-1:0] out
);

  import pixel_pkg::*;

  logic [CHAN_W-1:0] y;

  rgb_to_luma u_luma (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .data  (data),
    .y     (y)
  );

`ifdef THRESHOLD_EN
  localparam logic [CHAN_W-1:0] THR_Y = CHAN_W'(THRESHOLD);

  // S3: binarise luma into the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else if (en) begin
      out <= (y >= THR_Y) ? '1 : '0;
    end
  end
`else
  logic [31:0] unused_threshold;
  assign unused_threshold = THRESHOLD;

  // S3: replicate luma on all three channels into the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else if (en) begin
      out <= {3{y}};
    end
  end
`endif

endmodule

// File: tb/tb_pixel_proc_top.sv
// Directed and random checks of pixel_proc_top: reset, luma values, latency,
// enable freeze, mid-stream reset and a random stream against a luma model.
// Expected outputs follow the THRESHOLD_EN build when that macro is defined.
module tb_pixel_proc_top;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [23:0] data;
  logic [23:0] out_w;

  int errors = 0;
  int checks = 0;

  logic [23:0] m1, m2, mo;

  pixel_proc_top #(.PIXEL_SIZE(24), .THRESHOLD(128)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .data  (data),
    .out   (out_w)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] map_y(input int y);
`ifdef THRESHOLD_EN
    return (y >= 128) ? 24'hFFFFFF : 24'h000000;
`else
    return {3{8'(y)}};
`endif
  endfunction

  function automatic int luma(input logic [23:0] p);
    return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) >> 8;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] exp);
    checks++;
    assert (out_w === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, out_w, exp);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; data = 24'h0;
    tick(); tick();
    check("reset_state", 24'h0);

    // White constant stream: two zero edges, then white.
    reset = 1'b0; en = 1'b1; data = 24'hFFFFFF;
    tick(); check("white_e1", 24'h0);
    tick(); check("white_e2", 24'h0);
    tick(); check("white_e3", 24'hFFFFFF);
    tick(); check("white_e4", 24'hFFFFFF);

    // Pure primaries back-to-back.
    data = 24'hFF0000; tick(); check("prim_e1", 24'hFFFFFF);
    data = 24'h00FF00; tick(); check("prim_e2", 24'hFFFFFF);
    data = 24'h0000FF; tick(); check("red",   map_y('h4C));
    data = 24'h000000; tick(); check("green", map_y('h95));
    tick();                    check("blue",  map_y('h1C));
    tick();                    check("black", map_y(0));

    // Threshold boundary: Y=128 and Y=127.
    data = 24'h808080; tick(); check("thr_e1", 24'h0);
    data = 24'h7F7F7F; tick(); check("thr_e2", 24'h0);
    data = 24'h000000; tick(); check("y128", map_y(128));
    tick();                    check("y127", map_y(127));

    // Enable gap after b is captured.
    data = 24'h404040; tick(); check("gap_x_in", 24'h0);
    data = 24'hFF0000; tick(); check("gap_a_in", 24'h0);
    data = 24'h00FF00; tick(); check("gap_b_in", map_y(64));
    en = 1'b0; data = 24'h0000FF;
    tick(); check("gap_hold1", map_y(64));
    tick(); check("gap_hold2", map_y(64));
    tick(); check("gap_hold3", map_y(64));
    en = 1'b1;
    tick(); check("gap_a_out", map_y('h4C));
    data = 24'h000000;
    tick(); check("gap_b_out", map_y('h95));
    tick(); check("gap_c_out", map_y('h1C));

    // Mid-stream reset discards in-flight pixels.
    data = 24'hFFFFFF; tick(); tick(); tick();
    check("prerst_white", 24'hFFFFFF);
    reset = 1'b1; data = 24'hFF0000;
    tick(); check("rst_out0", 24'h0);
    reset = 1'b0; data = 24'h00FF00;
    tick(); check("rst_flush1", 24'h0);
    data = 24'h0000FF;
    tick(); check("rst_flush2", 24'h0);
    data = 24'h000000;
    tick(); check("rst_green", map_y('h95));
    tick(); check("rst_blue",  map_y('h1C));

    // Reset wins over en=0.
    reset = 1'b1; en = 1'b0;
    tick(); check("rst_over_en", 24'h0);

    // Random stream with random enable gaps against a luma model.
    tick();
    reset = 1'b0;
    m1 = '0; m2 = '0; mo = '0;
    for (int i = 0; i < 1000; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      data = 24'($urandom);
      tick();
      if (en) begin
        mo = map_y(luma(m2));
        m2 = m1;
        m1 = data;
      end
      check($sformatf("rand_%0d", i), mo);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
